// File: rtl/mux_scan_ctrl_pkg.sv
// rtl/mux_scan_ctrl_pkg.sv - shared constants, state type and helpers for the mux channel scanner
package mux_scan_ctrl_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Index of the lowest set bit; returns 0 for an empty mask.
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_next_chan.sv
// rtl/mux_scan_ctrl_next_chan.sv - next enabled channel strictly above cur, wrapping 3->0
//
// Ports:
//   mask  in  4  latched channel enable mask
//   cur   in  2  currently selected channel
//   nxt   out 2  next enabled channel after cur (cur itself if it is the only one)
//   wrap  out 1  nxt <= cur, i.e. the search wrapped and a frame completes
module scan_next_chan
    import mux_scan_ctrl_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  nxt,
    output logic              wrap
);

    logic [SEL_W-1:0] idx;
    logic             found;

    // Walk offsets 1..3 from cur; the 2-bit add wraps naturally. If nothing
    // else is enabled, the channel repeats itself and that still counts as a wrap.
    always_comb begin
        nxt   = cur;
        wrap  = 1'b1;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i < NUM_CH; i++) begin
            idx = cur + SEL_W'(i);
            if (!found && mask[idx]) begin
                found = 1'b1;
                nxt   = idx;
                wrap  = (idx < cur);
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - round-robin select generator and sampler for the 4:1 mux
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   en                  scan enable; dropping it while busy aborts the scan
//   start               one-cycle scan request
//   single_shot         1: one frame then stop; 0: continuous (sampled with start)
//   chan_mask[3:0]      channel enables, re-latched at each frame boundary
//   y_in                mux output
//   s1, s0              mux select lines, straight from the select register
//   busy                high while scanning
//   sample_valid        one-cycle strobe qualifying sample_chan / sample_bit
//   sample_chan[1:0]    channel of the last sample
//   sample_bit          captured y_in
//   frame[3:0]          last completed frame, disabled channels read 0
//   frame_valid         one-cycle strobe, frame updated
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        start,
    input  logic        single_shot,
    input  logic [3:0]  chan_mask,
    input  logic        y_in,
    output logic        s1,
    output logic        s0,
    output logic        busy,
    output logic        sample_valid,
    output logic [1:0]  sample_chan,
    output logic        sample_bit,
    output logic [3:0]  frame,
    output logic        frame_valid
);

    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                ss_q, ss_d;
    logic [NUM_CH-1:0]   shadow_q, shadow_d;
    logic [NUM_CH-1:0]   frame_q, frame_d;
    logic                fv_q, fv_d;
    logic                sv_q, sv_d;
    logic [SEL_W-1:0]    schan_q, schan_d;
    logic                sbit_q, sbit_d;
    logic [NUM_CH-1:0]   merged;
    logic [SEL_W-1:0]    nxt;
    logic                wrap;

    scan_next_chan u_next (
        .mask (mask_q),
        .cur  (sel_q),
        .nxt  (nxt),
        .wrap (wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            ss_q     <= 1'b0;
            shadow_q <= '0;
            frame_q  <= '0;
            fv_q     <= 1'b0;
            sv_q     <= 1'b0;
            schan_q  <= '0;
            sbit_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            ss_q     <= ss_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            fv_q     <= fv_d;
            sv_q     <= sv_d;
            schan_q  <= schan_d;
            sbit_q   <= sbit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        ss_d     = ss_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        fv_d     = 1'b0;
        sv_d     = 1'b0;
        schan_d  = schan_q;
        sbit_d   = sbit_q;

        // Shadow with the bit being sampled this edge already folded in.
        merged         = shadow_q;
        merged[sel_q]  = y_in;

        if (state_q == IDLE) begin
            if (start && en && (chan_mask != '0)) begin
                state_d  = SCAN;
                mask_d   = chan_mask;
                ss_d     = single_shot;
                sel_d    = lowest_set(chan_mask);
                cnt_d    = '0;
                shadow_d = '0;
            end
        end else begin
            if (!en) begin
                state_d = IDLE;
                sel_d   = '0;
            end else if (cnt_q != DWELL_M1) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                sv_d    = 1'b1;
                schan_d = sel_q;
                sbit_d  = y_in;
                cnt_d   = '0;
                if (!wrap) begin
                    shadow_d = merged;
                    sel_d    = nxt;
                end else begin
                    frame_d  = merged;
                    fv_d     = 1'b1;
                    shadow_d = '0;
                    if (ss_q) begin
                        state_d = IDLE;
                        sel_d   = '0;
                    end else begin
                        // Mask edits only take effect here, at a frame boundary.
                        mask_d = chan_mask;
                        if (chan_mask == '0) begin
                            state_d = IDLE;
                            sel_d   = '0;
                        end else begin
                            sel_d = lowest_set(chan_mask);
                        end
                    end
                end
            end
        end
    end

    assign s1           = sel_q[1];
    assign s0           = sel_q[0];
    assign busy         = (state_q == SCAN);
    assign sample_valid = sv_q;
    assign sample_chan  = schan_q;
    assign sample_bit   = sbit_q;
    assign frame        = frame_q;
    assign frame_valid  = fv_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl
module tb_mux_scan_ctrl;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst_n, en, start, single_shot, y_in;
    logic [3:0] chan_mask;
    logic       s1, s0, busy, sample_valid, sample_bit, frame_valid;
    logic [1:0] sample_chan;
    logic [3:0] frame;
    logic [3:0] ypat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Bench-side model of the 4:1 mux: y follows the selected channel's level.
    always_comb y_in = ypat[{s1, s0}];

    mux_scan_ctrl #(.DWELL(DWELL), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .start        (start),
        .single_shot  (single_shot),
        .chan_mask    (chan_mask),
        .y_in         (y_in),
        .s1           (s1),
        .s0           (s0),
        .busy         (busy),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .sample_bit   (sample_bit),
        .frame        (frame),
        .frame_valid  (frame_valid)
    );

    typedef struct {
        logic [3:0] mask;
        logic       ss;
        logic [3:0] ypat;
        int         n;      // enabled channels
        logic [7:0] chans;  // expected sample channel j in [2j+1:2j]
        logic [3:0] bits;   // expected sample bit j in [j]
        logic [3:0] frame;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int         lat, sel_err, stray, j;
        logic [1:0] ec;
        lat = DWELL * v.n;
        ypat = v.ypat;
        chan_mask = v.mask;
        single_shot = v.ss;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("first_sel", {s1, s0}, v.chans[1:0]);
        sel_err = 0;
        stray = 0;
        for (int t = 1; t <= lat; t++) begin
            cyc();
            if (t < lat) begin
                ec = v.chans[2*(t/DWELL) +: 2];
                if ({s1, s0} != ec) sel_err++;
                if (frame_valid) stray++;
            end
            if (t % DWELL == 0) begin
                j = t / DWELL - 1;
                check("sample_valid", sample_valid, 1);
                check("sample_chan", sample_chan, v.chans[2*j +: 2]);
                check("sample_bit", sample_bit, v.bits[j]);
            end else if (sample_valid) begin
                stray++;
            end
            if (t == lat) begin
                check("frame_valid", frame_valid, 1);
                check("frame", frame, v.frame);
                check("ss_busy_low", busy, 0);
                check("ss_sel_idle", {s1, s0}, 0);
            end
        end
        check("sel_sequence_errors", sel_err, 0);
        check("stray_strobes", stray, 0);
        cyc();
        check("post_frame_fv_low", frame_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; start = 1'b0; single_shot = 1'b1;
        chan_mask = 4'b0000; ypat = 4'b0000;

        vecs[0] = '{4'b1111, 1'b1, 4'b1010, 4, 8'b11_10_01_00, 4'b1010, 4'b1010};
        vecs[1] = '{4'b0101, 1'b1, 4'b1111, 2, 8'b00_00_10_00, 4'b0011, 4'b0101};
        vecs[2] = '{4'b1000, 1'b1, 4'b1111, 1, 8'b00_00_00_11, 4'b0001, 4'b1000};
        vecs[3] = '{4'b0110, 1'b1, 4'b0100, 2, 8'b00_00_10_01, 4'b0010, 4'b0100};
        vecs[4] = '{4'b1001, 1'b1, 4'b0001, 2, 8'b00_00_11_00, 4'b0001, 4'b0001};
        vecs[5] = '{4'b1011, 1'b1, 4'b0110, 3, 8'b00_11_01_00, 4'b0010, 4'b0010};

        // Reset state
        cyc(); cyc();
        check("rst_busy", busy, 0);
        check("rst_sel", {s1, s0}, 0);
        check("rst_frame", frame, 0);
        check("rst_sv", sample_valid, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_schan", sample_chan, 0);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Continuous two-channel scan: frame every 8 clocks, mask re-latched
        ypat = 4'b1111; chan_mask = 4'b0101; single_shot = 1'b0; start = 1'b1;
        cyc(); start = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            cyc();
            if (t == 8 || t == 16) begin
                check("cont_fv", frame_valid, 1);
                check("cont_frame", frame, 4'b0101);
                check("cont_busy", busy, 1);
                check("cont_sel_restart", {s1, s0}, 0);
            end
            if (t == 4) check("cont_sel_ch2", {s1, s0}, 2'd2);
            if (t == 6) check("cont_no_fv", frame_valid, 0);
        end
        en = 1'b0; cyc(); en = 1'b1;
        check("cont_abort_busy", busy, 0);

        // Single channel continuous, mask edit mid-frame
        ypat = 4'b1111; chan_mask = 4'b1000; single_shot = 1'b0; start = 1'b1;
        cyc(); start = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            cyc();
            if (t == 2) chan_mask = 4'b0011;
            if (t == 3) check("mask_edit_no_effect", {s1, s0}, 2'd3);
            if (t == 4) begin
                check("single_ch_fv", frame_valid, 1);
                check("single_ch_frame", frame, 4'b1000);
                check("new_mask_sel", {s1, s0}, 0);
            end
            if (t == 8) begin
                check("new_mask_schan", sample_chan, 0);
                check("new_mask_sel1", {s1, s0}, 1);
                check("new_mask_no_fv", frame_valid, 0);
            end
            if (t == 12) begin
                check("new_mask_fv", frame_valid, 1);
                check("new_mask_frame", frame, 4'b0011);
            end
        end
        en = 1'b0; cyc(); en = 1'b1;

        // Abort by dropping en at clock 6; frame keeps 0011
        ypat = 4'b1010; chan_mask = 4'b1111; single_shot = 1'b1; start = 1'b1;
        cyc(); start = 1'b0;
        for (int t = 1; t <= 5; t++) cyc();
        en = 1'b0;
        cyc();
        check("abort_busy", busy, 0);
        check("abort_sel", {s1, s0}, 0);
        check("abort_fv", frame_valid, 0);
        check("abort_sv", sample_valid, 0);
        check("abort_frame_kept", frame, 4'b0011);
        en = 1'b1;
        cyc();
        check("abort_stays_idle", busy, 0);

        // Ignored starts: empty mask, en low
        chan_mask = 4'b0000; start = 1'b1;
        cyc(); start = 1'b0;
        check("empty_mask_ignored", busy, 0);
        chan_mask = 4'b1111; en = 1'b0; start = 1'b1;
        cyc(); start = 1'b0; en = 1'b1;
        check("en_low_ignored", busy, 0);
        cyc();

        // start while busy does not disturb the running single-shot scan
        ypat = 4'b1010; chan_mask = 4'b1111; single_shot = 1'b1; start = 1'b1;
        cyc(); start = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            cyc();
            if (t == 5) begin start = 1'b1; chan_mask = 4'b0011; single_shot = 1'b0; end
            if (t == 6) start = 1'b0;
            if (t == 8) check("busy_start_schan", sample_chan, 1);
            if (t == 9) check("busy_start_sel", {s1, s0}, 2);
            if (t == 16) begin
                check("busy_start_fv", frame_valid, 1);
                check("busy_start_frame", frame, 4'b1010);
                check("busy_start_ss_kept", busy, 0);
            end
        end
        cyc();

        // Reset mid-scan, held for two edges
        chan_mask = 4'b1111; single_shot = 1'b1; start = 1'b1;
        cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_sel", {s1, s0}, 0);
        check("midrst_frame", frame, 0);
        check("midrst_sv", sample_valid, 0);
        check("midrst_fv", frame_valid, 0);

        // rst_n pulse between edges is not sampled
        chan_mask = 4'b0101; start = 1'b1;
        cyc(); start = 1'b0;
        rst_n = 1'b0; #2; rst_n = 1'b1;
        cyc();
        check("rst_glitch_ignored", busy, 1);
        check("rst_glitch_sel", {s1, s0}, 0);
        en = 1'b0; cyc(); en = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequential channel scanner that drives the S1/S0 select lines of the 4:1 combinational mux and samples the mux output y.
- Steps through the enabled channels in a round-robin.
- Holds each select for DWELL clocks, then samples y.
- Emits a per-sample strobe, and assembles a 4-bit frame (one bit per channel) once per full scan.
- Sits directly upstream (select generation) and downstream (output capture) of the mux in the lab datapath.

Parameters:
DWELL, 4, clocks each select is held; sample taken on the last one; legal range 2..255
CNT_W, 8, width of the dwell counter; must satisfy 2^CNT_W > DWELL

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
en  in  1  scan enable; low while busy aborts the scan
start  in  1  one-cycle request to begin scanning
single_shot  in  1  1: stop after one frame; 0: scan continuously; sampled with start
chan_mask  in  4  channel enable mask, bit i = channel i
y_in  in  1  mux output y
s1  out  1  mux select MSB
s0  out  1  mux select LSB
busy  out  1  high while scanning
sample_valid  out  1  one-cycle strobe: sample_bit/sample_chan valid
sample_chan  out  2  channel the sample belongs to
sample_bit  out  1  captured y_in
frame  out  4  last completed frame; disabled channels read 0
frame_valid  out  1  one-cycle strobe: frame updated

Behaviour:
- One clock domain. Reset is synchronous and active-low: rst_n low at a rising edge clears every output, the state, the counter and the shadow frame. The state is IDLE and {s1,s0}=00.
- States:
  - IDLE: busy=0, {s1,s0}=00.
  - SCAN: busy=1.
- IDLE -> SCAN when start=1, en=1 and chan_mask!=0. On that edge:
  - mask_q<=chan_mask and ss_q<=single_shot.
  - sel<=lowest set bit of chan_mask, cnt<=0.
  - shadow<=0.
- start with mask=0, or with en=0, is ignored. start while busy is ignored.
- SCAN, each edge:
  - If en=0: go to IDLE with sel<=00. No sample_valid or frame_valid; frame keeps its old value.
  - Else if cnt!=DWELL-1: cnt<=cnt+1.
  - Else (sample edge):
    - sample_bit<=y_in, sample_chan<=sel, sample_valid<=1.
    - shadow[sel]<=y_in, cnt<=0.
    - sel<=next set bit of mask_q strictly above sel, wrapping 3->0.
- Frame boundary: occurs on a sample edge where the next channel is <= the current channel (wrap, including the single-channel case). On that edge:
  - frame<=shadow with the current bit merged; frame_valid<=1; shadow<=0.
  - If ss_q=1: go to IDLE, sel<=00, busy<=0.
  - Else: mask_q<=chan_mask (re-latched). If the new mask is 0, go to IDLE. Otherwise sel<=lowest set bit of the new mask.
- chan_mask changes mid-frame have no effect until the next frame boundary.
- Timing and latency:
  - Each channel is selected for exactly DWELL clocks. y_in is sampled after DWELL-1 full settle cycles.
  - sample_valid is high in the cycle after the sample edge, coincident with the new select.
  - With start accepted at edge k: first sample_valid after edge k+DWELL; frame_valid after edge k+DWELL*popcount(mask).
- Strobes are registered and high for exactly one cycle. s1/s0 come directly from the registered sel, so they are glitch-free.

Decomposition:
- Shared package:
  - NUM_CH=4, SEL_W=2.
  - State enum {IDLE, SCAN}.
  - Function lowest_set(mask).
- One combinational sub-module, scan_next_chan.
  - Inputs: mask, cur.
  - Outputs: nxt[1:0] and wrap.
  - Behaviour: priority search above cur with wrap-around.

Test Plan:
1. Hold rst_n=0 for 2 edges mid-scan -> next cycle busy=0, {s1,s0}=00, frame=0, all strobes 0. Changing rst_n between edges has no effect.
2. DWELL=4, mask=1111, single_shot=1, y_in driven as channel pattern 0:0,1:1,2:0,3:1 -> sel 0,1,2,3 for 4 clocks each; 4 sample_valid pulses with sample_chan 0..3 and bits 0,1,0,1; frame_valid at edge k+16 with frame=4'b1010; busy low the same cycle.
3. mask=0101, continuous, y_in=1 -> sel alternates 0,2 every 4 clocks; frame_valid every 8 clocks with frame=4'b0101.
4. mask=1000, continuous -> sel stays 11; frame_valid every 4 clocks. Changing mask to 0011 mid-frame takes effect only after the next frame_valid, then sel runs 0,1.
5. Drop en at clock 6 of a 1111 scan -> next cycle IDLE, {s1,s0}=00, no frame_valid, frame unchanged.
6. start with mask=0000 -> no response, busy=0. start pulsed while busy -> scan sequence unchanged.
